fetch_unit: RTL and testbench
=============================

// Module: fetch_unit
// PURPOSE
//   Instruction-fetch stage of the P6 pipelined MIPS core: owns the PC, drives the
//   word address into the instruction memory, captures the returned word into the
//   IF/ID pipeline register. It is the requesting end of the instruction-memory
//   read interface (im: Addr[12:2] in, Out[31:0] back, combinational read).
// PARAMETERS
//   RESET_PC  32'h0000_3000  PC value loaded on reset
//   IM_BASE   32'h0000_3000  lowest legal fetch byte address (used by check option)
//   IM_LIMIT  32'h0000_4FFC  highest legal fetch byte address (used by check option)
//   NOP_WORD  32'h0000_0000  instruction word inserted on flush/reset/fault
// PORTS
//   clk          in   1   clock, all state updates on rising edge
//   reset        in   1   synchronous, active-high reset
//   stall        in   1   hold PC and IF/ID (hazard unit)
//   redirect_en  in   1   take redirect_pc as next PC (branch/jump resolved in D)
//   redirect_pc  in   32  target byte address
//   flush_d      in   1   replace the word entering IF/ID with NOP_WORD, valid_d=0
//   im_addr      out  11  word address to instruction memory = pc_f[12:2]
//   im_instr     in   32  instruction word returned combinationally by memory
//   pc_f         out  32  current fetch PC (F stage)
//   instr_d      out  32  IF/ID instruction
//   pc_d         out  32  IF/ID PC of instr_d
//   pc4_d        out  32  IF/ID pc_d + 4
//   valid_d      out  1   IF/ID holds a real fetched instruction
//   exc_d        out  1   IF/ID fetch address fault (0 constant when option off)
// BEHAVIOUR
//   - Reset (sampled at clk edge while reset=1): pc_f=RESET_PC, instr_d=NOP_WORD,
//     pc_d=0, pc4_d=0, valid_d=0, exc_d=0. Reset overrides every other input.
//   - im_addr is combinational from pc_f; fetch latency = 1 cycle (word fetched
//     at pc_f in cycle N appears on instr_d in cycle N+1).
//   - Priority per edge: reset > stall > flush_d/redirect_en > sequential.
//   - stall=1: pc_f and all IF/ID outputs hold; redirect_en and flush_d ignored
//     that cycle (hazard unit re-asserts them after stall drops).
//   - stall=0: IF/ID <= {im_instr, pc_f, pc_f+4, valid=1};
//     pc_f <= redirect_en ? redirect_pc : pc_f+4.
//   - flush_d=1 (stall=0): IF/ID <= {NOP_WORD, pc_f, pc_f+4, valid=0, exc=0};
//     pc_f still advances per redirect_en / +4. flush and redirect may coincide.
//   - Arithmetic: pc_f+4 is 32-bit modulo; 32'hFFFF_FFFC wraps to 32'h0000_0000.
//   - redirect_pc is stored verbatim; low 2 bits never reach im_addr.
//   - No internal FSM beyond PC + IF/ID register; delay slot is architectural
//     (the instruction after a branch is always fetched; redirect applies next).
// CONFIGURATION
//   FETCH_ADDR_CHECK_EN defined:
//     - fault = (pc_f[1:0]!=0) | (pc_f<IM_BASE) | (pc_f>IM_LIMIT), evaluated in F.
//     - on stall=0 and fault: instr_d=NOP_WORD, valid_d=1, exc_d=1, pc_d=pc_f
//       (faulting PC kept for EPC); PC advance unchanged.
//     - flush_d clears exc_d to 0.
//   Not defined: no comparators, exc_d tied 0, im_instr always captured.
// TESTING
//   1 reset 2 cycles, release -> pc_f=0x3000, im_addr=0x400, valid_d=0, instr_d=0.
//   2 run 3 cycles, mem[0x400..0x402]=A,B,C -> instr_d A,B,C; pc_d 0x3000,0x3004,
//     0x3008; pc4_d = pc_d+4; valid_d=1.
//   3 stall=1 for 2 cycles with redirect_en=1 -> pc_f, instr_d, pc_d unchanged;
//     stall=0 with redirect_en=1, redirect_pc=0x3100 -> next pc_f=0x3100.
//   4 flush_d=1 + redirect 0x3200 at pc_f=0x3010 -> instr_d=0, valid_d=0,
//     pc_d=0x3010, pc_f=0x3200; flush_d+stall together -> hold, no clear.
//   5 redirect 0xFFFF_FFFC, step 1 -> pc_f=0x0000_0000; assert reset mid-run
//     -> pc_f=0x3000, valid_d=0 on the next edge.
//   6 FETCH_ADDR_CHECK_EN: redirect 0x3002 -> exc_d=1, instr_d=0, pc_d=0x3002;
//     redirect 0x5000 -> exc_d=1; redirect 0x4FFC -> exc_d=0; option off -> exc_d=0.

Source files
------------

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, drives the word address to instruction memory, captures the IF/ID register.
// Latency: im_addr is combinational from pc_f; the word fetched at pc_f in cycle N appears on instr_d in cycle N+1.
// Backpressure: stall=1 freezes pc_f and IF/ID and drops that cycle's redirect/flush. Option macro: FETCH_ADDR_CHECK_EN.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000,
  parameter logic [31:0] IM_BASE  = 32'h0000_3000,
  parameter logic [31:0] IM_LIMIT = 32'h0000_4FFC,
  parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        redirect_en,
  input  logic [31:0] redirect_pc,
  input  logic        flush_d,
  output logic [10:0] im_addr,
  input  logic [31:0] im_instr,
  output logic [31:0] pc_f,
  output logic [31:0] instr_d,
  output logic [31:0] pc_d,
  output logic [31:0] pc4_d,
  output logic        valid_d,
  output logic        exc_d
);

  logic [31:0] pc_f_q, pc_f_d;
  logic [31:0] instr_d_q, instr_d_d;
  logic [31:0] pc_d_q, pc_d_d;
  logic [31:0] pc4_d_q, pc4_d_d;
  logic        valid_d_q, valid_d_d;
  logic        exc_d_q, exc_d_d;
  logic [31:0] pc_plus4;
  logic        fault;

  // 32-bit modulo increment, so 0xFFFF_FFFC wraps to zero
  assign pc_plus4 = pc_f_q + 32'd4;

  // Memory only sees the word index; redirect_pc low bits are kept in pc_f but never reach the memory
  assign im_addr  = pc_f_q[12:2];

`ifdef FETCH_ADDR_CHECK_EN
  // Fault is judged on the PC currently being fetched, so pc_d keeps the offending address for EPC
  assign fault = (pc_f_q[1:0] != 2'b00) | (pc_f_q < IM_BASE) | (pc_f_q > IM_LIMIT);
`else
  assign fault = 1'b0;
  // Address window only matters when checking is built in
  logic unused_cfg;
  assign unused_cfg = ^{IM_BASE, IM_LIMIT};
`endif

  // Next-state for PC and IF/ID: hold on stall, otherwise capture F and advance the PC
  always_comb begin
    pc_f_d    = pc_f_q;
    instr_d_d = instr_d_q;
    pc_d_d    = pc_d_q;
    pc4_d_d   = pc4_d_q;
    valid_d_d = valid_d_q;
    exc_d_d   = exc_d_q;
    if (!stall) begin
      pc_f_d  = redirect_en ? redirect_pc : pc_plus4;
      pc_d_d  = pc_f_q;
      pc4_d_d = pc_plus4;
      if (flush_d) begin
        instr_d_d = NOP_WORD;
        valid_d_d = 1'b0;
        exc_d_d   = 1'b0;
      end else if (fault) begin
        instr_d_d = NOP_WORD;
        valid_d_d = 1'b1;
        exc_d_d   = 1'b1;
      end else begin
        instr_d_d = im_instr;
        valid_d_d = 1'b1;
        exc_d_d   = 1'b0;
      end
    end
  end

  // State registers; synchronous reset overrides stall, flush and redirect
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_f_q    <= RESET_PC;
      instr_d_q <= NOP_WORD;
      pc_d_q    <= 32'd0;
      pc4_d_q   <= 32'd0;
      valid_d_q <= 1'b0;
      exc_d_q   <= 1'b0;
    end else begin
      pc_f_q    <= pc_f_d;
      instr_d_q <= instr_d_d;
      pc_d_q    <= pc_d_d;
      pc4_d_q   <= pc4_d_d;
      valid_d_q <= valid_d_d;
      exc_d_q   <= exc_d_d;
    end
  end

  assign pc_f    = pc_f_q;
  assign instr_d = instr_d_q;
  assign pc_d    = pc_d_q;
  assign pc4_d   = pc4_d_q;
  assign valid_d = valid_d_q;
  assign exc_d   = exc_d_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios then randomized control, checked against a transaction-level model.
// Latency: outputs compared on the falling edge after each rising edge.
// Backpressure: stall driven randomly; the model freezes on stall.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall;
  logic        redirect_en;
  logic [31:0] redirect_pc;
  logic        flush_d;
  logic [10:0] im_addr;
  logic [31:0] im_instr;
  logic [31:0] pc_f, instr_d, pc_d, pc4_d;
  logic        valid_d, exc_d;

  logic [31:0] mem [0:2047];

  // reference model state
  logic [31:0] m_pc, m_instr, m_pcd, m_pc4d;
  logic        m_valid, m_exc;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  assign im_instr = mem[im_addr];

  fetch_unit dut (
    .clk        (clk),
    .reset      (reset),
    .stall      (stall),
    .redirect_en(redirect_en),
    .redirect_pc(redirect_pc),
    .flush_d    (flush_d),
    .im_addr    (im_addr),
    .im_instr   (im_instr),
    .pc_f       (pc_f),
    .instr_d    (instr_d),
    .pc_d       (pc_d),
    .pc4_d      (pc4_d),
    .valid_d    (valid_d),
    .exc_d      (exc_d)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit addr_fault(input logic [31:0] a);
`ifdef FETCH_ADDR_CHECK_EN
    return (a % 4 != 0) || (a < 32'h3000) || (a > 32'h4FFC);
`else
    return 1'b0;
`endif
  endfunction

  // Apply one cycle of control, advance the model by the rules of one clock edge, then compare everything.
  task automatic step(input bit rst, input bit st, input bit re, input logic [31:0] rpc, input bit fl);
    logic [31:0] word;
    reset = rst; stall = st; redirect_en = re; redirect_pc = rpc; flush_d = fl;
    @(posedge clk);
    if (rst) begin
      m_pc = 32'h3000; m_instr = 32'h0; m_pcd = 32'h0; m_pc4d = 32'h0; m_valid = 0; m_exc = 0;
    end else if (!st) begin
      word   = mem[(m_pc / 4) % 2048];
      m_pcd  = m_pc;
      m_pc4d = m_pc + 32'd4;
      if (fl)                   begin m_instr = 32'h0; m_valid = 0; m_exc = 0; end
      else if (addr_fault(m_pc)) begin m_instr = 32'h0; m_valid = 1; m_exc = 1; end
      else                      begin m_instr = word;  m_valid = 1; m_exc = 0; end
      m_pc = re ? rpc : m_pc + 32'd4;
    end
    @(negedge clk);
    chk("pc_f",    pc_f,    m_pc);
    chk("im_addr", {21'd0, im_addr}, (m_pc / 4) % 2048);
    chk("instr_d", instr_d, m_instr);
    chk("pc_d",    pc_d,    m_pcd);
    chk("pc4_d",   pc4_d,   m_pc4d);
    chk("valid_d", {31'd0, valid_d}, {31'd0, m_valid});
    chk("exc_d",   {31'd0, exc_d},   {31'd0, m_exc});
  endtask

  initial begin
    logic [31:0] hold_pc, hold_instr, hold_pcd, rpc;
    bit st, re, fl, rs;
    for (int i = 0; i < 2048; i++) mem[i] = $urandom | 32'h1;
    reset = 1; stall = 0; redirect_en = 0; redirect_pc = 0; flush_d = 0;
    m_pc = 0; m_instr = 0; m_pcd = 0; m_pc4d = 0; m_valid = 0; m_exc = 0;
    @(negedge clk);

    // 1: reset for two cycles
    step(1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    chk("rst_pc",    pc_f, 32'h3000);
    chk("rst_addr",  {21'd0, im_addr}, 32'h400);
    chk("rst_instr", instr_d, 32'h0);
    chk("rst_valid", {31'd0, valid_d}, 32'd0);

    // 2: three sequential fetches
    step(0, 0, 0, 0, 0);
    chk("seq_a", instr_d, mem[11'h400]);
    chk("seq_a_pc", pc_d, 32'h3000);
    step(0, 0, 0, 0, 0);
    chk("seq_b", instr_d, mem[11'h401]);
    step(0, 0, 0, 0, 0);
    chk("seq_c", instr_d, mem[11'h402]);
    chk("seq_c_pc4", pc4_d, 32'h300C);

    // 3: stall ignores redirect, then redirect lands
    hold_pc = pc_f; hold_instr = instr_d; hold_pcd = pc_d;
    step(0, 1, 1, 32'h3100, 0);
    step(0, 1, 1, 32'h3100, 0);
    chk("stall_pc",    pc_f,    hold_pc);
    chk("stall_instr", instr_d, hold_instr);
    chk("stall_pcd",   pc_d,    hold_pcd);
    step(0, 0, 1, 32'h3100, 0);
    chk("redir_pc", pc_f, 32'h3100);

    // 4: flush with redirect, then flush under stall
    step(0, 0, 1, 32'h3010, 0);
    step(0, 0, 1, 32'h3200, 1);
    chk("flush_instr", instr_d, 32'h0);
    chk("flush_valid", {31'd0, valid_d}, 32'd0);
    chk("flush_pcd",   pc_d, 32'h3010);
    chk("flush_pcf",   pc_f, 32'h3200);
    step(0, 0, 0, 0, 0);
    hold_instr = instr_d;
    step(0, 1, 0, 0, 1);
    chk("fst_instr", instr_d, hold_instr);
    chk("fst_valid", {31'd0, valid_d}, 32'd1);

    // 5: wraparound, then reset mid-run
    step(0, 0, 1, 32'hFFFF_FFFC, 0);
    step(0, 0, 0, 0, 0);
    chk("wrap_pc", pc_f, 32'h0);
    step(1, 1, 1, 32'h1234, 1);
    chk("midrst_pc",    pc_f, 32'h3000);
    chk("midrst_valid", {31'd0, valid_d}, 32'd0);

    // 6: address window check (or its absence)
    step(0, 0, 1, 32'h3002, 0);
    step(0, 0, 1, 32'h5000, 0);
`ifdef FETCH_ADDR_CHECK_EN
    chk("mis_exc",   {31'd0, exc_d}, 32'd1);
    chk("mis_instr", instr_d, 32'h0);
    chk("mis_pcd",   pc_d, 32'h3002);
`endif
    step(0, 0, 1, 32'h4FFC, 0);
`ifdef FETCH_ADDR_CHECK_EN
    chk("hi_exc", {31'd0, exc_d}, 32'd1);
`else
    chk("off_exc", {31'd0, exc_d}, 32'd0);
`endif
    step(0, 0, 0, 0, 0);
    chk("lim_exc", {31'd0, exc_d}, 32'd0);

    // random control traffic
    for (int i = 0; i < 400; i++) begin
      rs = ($urandom_range(0, 99) < 3);
      st = ($urandom_range(0, 99) < 25);
      re = ($urandom_range(0, 99) < 20);
      fl = ($urandom_range(0, 99) < 15);
      case ($urandom_range(0, 3))
        0:       rpc = $urandom;
        1:       rpc = 32'h3000 + ($urandom_range(0, 2047) * 4);
        2:       rpc = 32'h2FF0 + $urandom_range(0, 15);
        default: rpc = 32'h4FF0 + $urandom_range(0, 31);
      endcase
      step(rs, st, re, rpc, fl);
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
